// File: rtl/sprite_compositor.sv
// Two-stage pixel compositor: priority/colour-key layer resolve, test and solid modes,
// a frame-locked fade-out/fade-in transition and a free-running animation frame counter.
module sprite_compositor #(
    parameter int          NUM_LAYERS  = 8,
    parameter logic [23:0] TRANSPARENT = 24'hFFFFFF,
    parameter int          ANIM_FRAMES = 4,
    parameter int          ANIM_DIV    = 8,
    parameter int          FADE_MAX    = 16
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             pixel_valid,
    input  logic [9:0]                       DrawX,
    input  logic [9:0]                       DrawY,
    input  logic                             frame_start,
    input  logic [NUM_LAYERS-1:0]            layer_hit,
    input  logic [24*NUM_LAYERS-1:0]         layer_color,
    input  logic [NUM_LAYERS-1:0]            layer_key_en,
    input  logic [23:0]                      bg_color,
    input  logic [1:0]                       mode,
    input  logic                             fade_start,
    output logic [7:0]                       VGA_R,
    output logic [7:0]                       VGA_G,
    output logic [7:0]                       VGA_B,
    output logic                             pix_valid_out,
    output logic [$clog2(NUM_LAYERS):0]      win_layer,
    output logic [$clog2(ANIM_FRAMES)-1:0]   anim_frame,
    output logic                             fade_busy
);

    localparam int WIN_W       = $clog2(NUM_LAYERS) + 1;
    localparam int AF_W        = $clog2(ANIM_FRAMES);
    localparam int DIV_W       = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int LVL_W       = $clog2(FADE_MAX) + 1;
    localparam int FADE_SHIFT  = $clog2(FADE_MAX);

    typedef enum logic [1:0] {
        FADE_IDLE,
        FADE_OUT,
        FADE_HOLD,
        FADE_IN
    } fade_state_t;

    fade_state_t        fade_state;
    logic [LVL_W-1:0]   fade_level;
    logic [DIV_W-1:0]   div_cnt;

    logic [WIN_W-1:0]   win_idx;
    logic [23:0]        win_color;
    logic [WIN_W-1:0]   mode_win;
    logic [23:0]        mode_color;
    logic [7:0]         grad_b;

    logic               s1_valid;
    logic [23:0]        s1_color;
    logic [WIN_W-1:0]   s1_win;

    // DrawY and the low DrawX bits are part of the pixel bus but unused by this block.
    logic unused_inputs;
    assign unused_inputs = ^{DrawY, DrawX[2:0]};

    assign grad_b = 8'h7F - {1'b0, DrawX[9:3]};

    // NOTE: every variable gets a default before the loop/case so no latch is inferred.
    always_comb begin
        win_idx   = '1;
        win_color = bg_color;
        // Walk from lowest priority upward so the lowest eligible index is the last write.
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_hit[i] &&
                !(layer_key_en[i] && (layer_color[24*i +: 24] == TRANSPARENT))) begin
                win_idx   = WIN_W'(i);
                win_color = layer_color[24*i +: 24];
            end
        end
    end

    always_comb begin
        mode_win   = '1;
        mode_color = bg_color;
        case (mode)
            2'b00: begin
                mode_win   = win_idx;
                mode_color = win_color;
            end
            2'b01:   mode_color = {8'h7B, 8'hFF, grad_b};
            default: mode_color = bg_color;
        endcase
    end

    function automatic logic [7:0] scale(input logic [7:0] ch, input logic [LVL_W-1:0] lvl);
        return 8'(({5'd0, ch} * {8'd0, lvl}) >> FADE_SHIFT);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid      <= 1'b0;
            s1_color      <= '0;
            s1_win        <= '1;
            VGA_R         <= '0;
            VGA_G         <= '0;
            VGA_B         <= '0;
            pix_valid_out <= 1'b0;
            win_layer     <= '1;
        end else begin
            // Blanked pixels carry black and the background index through the pipe.
            s1_valid      <= pixel_valid;
            s1_color      <= pixel_valid ? mode_color : 24'h000000;
            s1_win        <= pixel_valid ? mode_win : '1;
            VGA_R         <= scale(s1_color[23:16], fade_level);
            VGA_G         <= scale(s1_color[15:8],  fade_level);
            VGA_B         <= scale(s1_color[7:0],   fade_level);
            pix_valid_out <= s1_valid;
            win_layer     <= s1_win;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fade_state <= FADE_IDLE;
            fade_level <= LVL_W'(FADE_MAX);
            fade_busy  <= 1'b0;
        end else begin
            case (fade_state)
                FADE_IDLE: begin
                    // A coincident frame_start does not decrement on entry.
                    if (fade_start) begin
                        fade_state <= FADE_OUT;
                        fade_busy  <= 1'b1;
                    end
                end
                FADE_OUT: begin
                    if (frame_start) begin
                        fade_level <= fade_level - LVL_W'(1);
                        if (fade_level == LVL_W'(1)) fade_state <= FADE_HOLD;
                    end
                end
                FADE_HOLD: begin
                    if (frame_start) fade_state <= FADE_IN;
                end
                FADE_IN: begin
                    if (frame_start) begin
                        fade_level <= fade_level + LVL_W'(1);
                        if (fade_level == LVL_W'(FADE_MAX - 1)) begin
                            fade_state <= FADE_IDLE;
                            fade_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    fade_state <= FADE_IDLE;
                    fade_level <= LVL_W'(FADE_MAX);
                    fade_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_cnt    <= '0;
            anim_frame <= '0;
        end else if (frame_start) begin
            if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
                div_cnt    <= '0;
                anim_frame <= (anim_frame == AF_W'(ANIM_FRAMES - 1)) ? '0 : anim_frame + AF_W'(1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule
